// File: rtl/rle_frame_scheduler.sv
//============================================================================
// Module : rle_frame_scheduler
// Desc   : In-order descriptor queue that feeds a single RLE engine. It screens
//          out illegal frames, recovers a hung engine and keeps running totals.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module rle_frame_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_MSG_SIZE   = 255
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_msg_addr,
  input  logic [31:0] desc_msg_size,
  input  logic [31:0] desc_rle_addr,
  input  logic [3:0]  desc_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_tag,
  output logic [31:0] res_size,
  output logic        res_error,
  output logic        eng_start,
  output logic [31:0] eng_message_addr,
  output logic [31:0] eng_message_size,
  output logic [31:0] eng_rle_addr,
  output logic        eng_nreset,
  input  logic        eng_done,
  input  logic [31:0] eng_rle_size,
  output logic        busy,
  output logic [15:0] frames_done,
  output logic [31:0] bytes_total
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_fifo_full = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] c_max_size  = 32'(MAX_MSG_SIZE);
  localparam logic [15:0] c_tmo_last  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RECOVER   = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_fifo_msg_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_msg_size [FIFO_DEPTH];
  logic [31:0]   r_fifo_rle_addr [FIFO_DEPTH];
  logic [3:0]    r_fifo_tag      [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [31:0] r_job_msg_addr;
  logic [31:0] r_job_msg_size;
  logic [31:0] r_job_rle_addr;
  logic [3:0]  r_res_tag;
  logic [31:0] r_res_size;
  logic        r_res_error;
  logic [15:0] r_tmo;
  logic        r_rec_second;
  logic        r_recover;
  logic [15:0] r_frames;
  logic [31:0] r_bytes;

  logic        w_push;
  logic        w_pop;
  logic        w_timeout;
  logic [31:0] w_head_size;
  logic        w_head_zero;
  logic        w_head_big;

  // Ready depends on the count alone, so a same-cycle pop never opens a slot.
  assign desc_ready  = (r_count != c_fifo_full);
  assign w_push      = desc_valid && desc_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !res_valid;
  assign w_head_size = r_fifo_msg_size[r_rd_ptr];
  assign w_head_zero = (w_head_size == 32'd0);
  assign w_head_big  = (w_head_size > c_max_size);
  assign w_timeout   = (r_tmo == c_tmo_last);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_msg_addr[r_wr_ptr] <= desc_msg_addr;
      r_fifo_msg_size[r_wr_ptr] <= desc_msg_size;
      r_fifo_rle_addr[r_wr_ptr] <= desc_rle_addr;
      r_fifo_tag[r_wr_ptr]      <= desc_tag;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if (w_head_zero || w_head_big) w_state_next = S_REPORT;
          else                           w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      // done may still be high from the previous job, so only its fall counts
      S_WAIT_BUSY: begin
        if (w_timeout)     w_state_next = S_RECOVER;
        else if (!eng_done) w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_timeout)    w_state_next = S_RECOVER;
        else if (eng_done) w_state_next = S_REPORT;
      end
      S_RECOVER: begin
        if (r_rec_second) w_state_next = S_REPORT;
      end
      S_REPORT: begin
        if (res_ready) w_state_next = S_IDLE;
      end
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_job_msg_addr <= '0;
      r_job_msg_size <= '0;
      r_job_rle_addr <= '0;
      r_res_tag      <= '0;
      r_res_size     <= '0;
      r_res_error    <= 1'b0;
      r_tmo          <= '0;
      r_rec_second   <= 1'b0;
      r_recover      <= 1'b0;
      r_frames       <= '0;
      r_bytes        <= '0;
    end else begin
      // Registered decode keeps the engine reset free of state-decode glitches.
      r_recover <= (w_state_next == S_RECOVER);
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_job_msg_addr <= r_fifo_msg_addr[r_rd_ptr];
            r_job_msg_size <= w_head_size;
            r_job_rle_addr <= r_fifo_rle_addr[r_rd_ptr];
            r_res_tag      <= r_fifo_tag[r_rd_ptr];
            r_res_size     <= '0;
            r_res_error    <= w_head_big;
          end
        end
        S_LAUNCH: r_tmo <= '0;
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_tmo        <= r_tmo + 1'b1;
          r_rec_second <= 1'b0;
          if (w_timeout) begin
            r_res_size  <= '0;
            r_res_error <= 1'b1;
          end else if ((r_state == S_WAIT_DONE) && eng_done) begin
            r_res_size  <= eng_rle_size;
            r_res_error <= 1'b0;
          end
        end
        S_RECOVER: r_rec_second <= 1'b1;
        S_REPORT: begin
          if (res_ready) begin
            r_frames <= r_frames + 1'b1;
            r_bytes  <= r_bytes + r_res_size;
          end
        end
        default: r_tmo <= r_tmo;
      endcase
    end
  end

  assign res_valid        = (r_state == S_REPORT);
  assign res_tag          = r_res_tag;
  assign res_size         = r_res_size;
  assign res_error        = r_res_error;
  assign eng_start        = (r_state == S_LAUNCH);
  assign eng_message_addr = r_job_msg_addr;
  assign eng_message_size = r_job_msg_size;
  assign eng_rle_addr     = r_job_rle_addr;
  assign eng_nreset       = nreset & ~r_recover;
  assign busy             = (r_state != S_IDLE) || (r_count != '0);
  assign frames_done      = r_frames;
  assign bytes_total      = r_bytes;

endmodule

`default_nettype wire
